phase_generator: RTL
====================

PHASE_GENERATOR -- requirements
Module: phase_generator

Interface
REQ-001 Parameter NUM_VOICES, 32, number of time-multiplexed voices (power of two, 2..256).
REQ-002 Parameter PHASE_WIDTH, 24, phase accumulator and increment width (>= 13).
REQ-003 i_Clock  input  1  single clock; all state on rising edge.
REQ-004 i_Reset  input  1  asynchronous, active-high reset.
REQ-005 i_SampleStart  input  1  one-cycle pulse starting a sweep over all voices.
REQ-006 i_WriteEnable  input  1  increment write strobe.
REQ-007 i_WriteVoice  input  log2(NUM_VOICES)  voice addressed by the write.
REQ-008 i_WriteIncrement  input  PHASE_WIDTH  new phase increment (frequency word).
REQ-009 i_WriteResetPhase  input  1  with i_WriteEnable: clear that voice's phase.
REQ-010 i_Modulation  input  13 signed  phase offset for the voice being read this cycle.
REQ-011 o_Argument  output  13  phase argument for the downstream sine lookup.
REQ-012 o_Voice  output  log2(NUM_VOICES)  voice index of o_Argument.
REQ-013 o_Valid  output  1  o_Argument/o_Voice valid this cycle.
REQ-014 o_Busy  output  1  sweep in progress.
REQ-015 o_Overrun  output  1  sticky: i_SampleStart arrived while busy.

Function
REQ-016 States IDLE and SWEEP; IDLE->SWEEP on i_SampleStart; SWEEP->IDLE after voice NUM_VOICES-1 is read.
REQ-017 i_SampleStart in cycle t: voice k read in cycle t+1+k, k = 0..NUM_VOICES-1; o_Busy high t+1..t+NUM_VOICES.
REQ-018 Voice k output registered in cycle t+2+k: o_Valid high exactly NUM_VOICES consecutive cycles, o_Voice = k.
REQ-019 o_Argument = (phase[k] before update)[PHASE_WIDTH-1 -: 13] + i_Modulation sampled in read cycle, modulo 2^13.
REQ-020 Read cycle stores phase[k] <= phase[k] + increment[k], modulo 2^PHASE_WIDTH (wrap, no saturation).
REQ-021 Voices not read in a sweep keep their phase; IDLE changes no phase.
REQ-022 Writes accepted in any state; increment[v] updated at the clock edge.
REQ-023 Write to voice being read in same cycle: read uses old increment; new value applies next sweep.
REQ-024 i_WriteResetPhase on voice being read in same cycle: stored phase = 0 (reset beats accumulate); output uses pre-update phase.
REQ-025 i_SampleStart while o_Busy or in last read cycle: ignored, o_Overrun set; cleared only by reset.
REQ-026 When o_Valid low: o_Argument, o_Voice hold last values.

Reset
REQ-027 Reset: state IDLE, all phases 0, all increments 0, o_Argument 0, o_Voice 0, o_Valid 0, o_Busy 0, o_Overrun 0.
REQ-028 Reset mid-sweep: outputs drop the same instant (asynchronous); no further o_Valid until next i_SampleStart.
REQ-029 First i_SampleStart sampled in the first rising edge after reset deasserts.

Configuration
REQ-030 Macro PHASE_GENERATOR_MODULATION_EN defined: i_Modulation added per REQ-019.
REQ-031 Macro undefined: port kept, ignored; o_Argument = top 13 phase bits; latency unchanged.

Verification (NUM_VOICES=32, PHASE_WIDTH=24, macro defined unless noted)
REQ-032 Voice 0 increment 0x000800, i_Modulation 0, sweeps 0..4 -> voice 0 o_Argument 0,1,2,3,4.
REQ-033 Voice 3 increment 0x800000 -> voice 3 o_Argument 0x0000,0x1000,0x0000,... (wrap at 2^24).
REQ-034 Voice 0 phase 0x000800, i_Modulation 0x1FFF (-1) -> o_Argument 0x0000; macro undefined -> 0x0001.
REQ-035 i_SampleStart at t, again at t+5 -> o_Valid t+2..t+33 only, o_Overrun 1 from t+6.
REQ-036 i_Reset mid-sweep (voice 10) -> o_Valid 0 immediately; next sweep gives all voices o_Argument 0.

Source files
------------

// File: rtl/phase_generator_if.sv
// Bundle of the sweep control, increment write port, modulation input and
// argument outputs of phase_generator; master drives requests, slave is the generator.
interface phase_generator_if #(
  parameter int NUM_VOICES  = 32,
  parameter int PHASE_WIDTH = 24
);
  localparam int VOICE_W = $clog2(NUM_VOICES);

  logic                   i_SampleStart;
  logic                   i_WriteEnable;
  logic [VOICE_W-1:0]     i_WriteVoice;
  logic [PHASE_WIDTH-1:0] i_WriteIncrement;
  logic                   i_WriteResetPhase;
  logic signed [12:0]     i_Modulation;
  logic [12:0]            o_Argument;
  logic [VOICE_W-1:0]     o_Voice;
  logic                   o_Valid;
  logic                   o_Busy;
  logic                   o_Overrun;

  modport master (
    output i_SampleStart, i_WriteEnable, i_WriteVoice, i_WriteIncrement,
           i_WriteResetPhase, i_Modulation,
    input  o_Argument, o_Voice, o_Valid, o_Busy, o_Overrun
  );

  modport slave (
    input  i_SampleStart, i_WriteEnable, i_WriteVoice, i_WriteIncrement,
           i_WriteResetPhase, i_Modulation,
    output o_Argument, o_Voice, o_Valid, o_Busy, o_Overrun
  );
endinterface

// File: rtl/phase_generator.sv
// Time-multiplexed phase accumulator: one voice per cycle per sweep, 13-bit argument out.
// Define PHASE_GENERATOR_MODULATION_EN to add i_Modulation to the argument.
module phase_generator #(
  parameter int NUM_VOICES  = 32,
  parameter int PHASE_WIDTH = 24
) (
  input logic               i_Clock,
  input logic               i_Reset,
  phase_generator_if.slave  bus
);
  localparam int VOICE_W = $clog2(NUM_VOICES);
  localparam int ARG_W   = 13;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                 state_q, state_d;
  logic [VOICE_W-1:0]     read_voice_q, read_voice_d;
  logic                   overrun_q, overrun_d;
  logic [PHASE_WIDTH-1:0] phase_q     [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] phase_d     [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] increment_q [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] increment_d [NUM_VOICES];
  logic [ARG_W-1:0]       argument_q, argument_d;
  logic [VOICE_W-1:0]     voice_q, voice_d;
  logic                   valid_q, valid_d;

  logic                   reading;
  logic                   last_read;
  logic [PHASE_WIDTH-1:0] read_phase;
  logic [PHASE_WIDTH-1:0] read_increment;
  logic [ARG_W-1:0]       read_argument;

  assign reading        = (state_q == SWEEP);
  assign last_read      = (read_voice_q == VOICE_W'(NUM_VOICES - 1));
  assign read_phase     = phase_q[read_voice_q];
  assign read_increment = increment_q[read_voice_q];

`ifdef PHASE_GENERATOR_MODULATION_EN
  assign read_argument = read_phase[PHASE_WIDTH-1 -: ARG_W] + bus.i_Modulation;
`else
  logic unused_modulation;
  assign unused_modulation = ^bus.i_Modulation;
  assign read_argument     = read_phase[PHASE_WIDTH-1 -: ARG_W];
`endif

  // A start seen in any SWEEP cycle, including the last read, is an overrun.
  always_comb begin
    state_d      = state_q;
    read_voice_d = read_voice_q;
    overrun_d    = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_SampleStart) begin
          state_d      = SWEEP;
          read_voice_d = '0;
        end
      end
      SWEEP: begin
        if (bus.i_SampleStart) overrun_d = 1'b1;
        read_voice_d = read_voice_q + VOICE_W'(1);
        if (last_read) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-side phase clear is applied after the accumulate so it wins on a collision.
  always_comb begin
    phase_d     = phase_q;
    increment_d = increment_q;
    if (reading) phase_d[read_voice_q] = read_phase + read_increment;
    if (bus.i_WriteEnable) begin
      increment_d[bus.i_WriteVoice] = bus.i_WriteIncrement;
      if (bus.i_WriteResetPhase) phase_d[bus.i_WriteVoice] = '0;
    end
  end

  always_comb begin
    argument_d = argument_q;
    voice_d    = voice_q;
    valid_d    = reading;
    if (reading) begin
      argument_d = read_argument;
      voice_d    = read_voice_q;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= IDLE;
      read_voice_q <= '0;
      overrun_q    <= 1'b0;
      argument_q   <= '0;
      voice_q      <= '0;
      valid_q      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i]     <= '0;
        increment_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      read_voice_q <= read_voice_d;
      overrun_q    <= overrun_d;
      argument_q   <= argument_d;
      voice_q      <= voice_d;
      valid_q      <= valid_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i]     <= phase_d[i];
        increment_q[i] <= increment_d[i];
      end
    end
  end

  assign bus.o_Argument = argument_q;
  assign bus.o_Voice    = voice_q;
  assign bus.o_Valid    = valid_q;
  assign bus.o_Busy     = reading;
  assign bus.o_Overrun  = overrun_q;
endmodule
